// File: rtl/gbt_link_mon_pkg.sv
// Shared types and helpers for the GBT link monitor.
// State encoding is fixed because state_o is read by slow control.
package gbt_link_mon_pkg;

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_UP      = 2'd2,
        ST_DROP    = 2'd3
    } gbt_state_e;

    // Saturating increment for a counter of the given width (1..32); the caller truncates.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module bit_sync_2ff (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gbt_link_monitor.sv
// Qualifies/debounces GBT link status and counts glitches and unlocks.
// Define GBT_LINK_MON_SYNC_EN to pass raw inputs through 2-flop synchronizers first.
module gbt_link_monitor
    import gbt_link_mon_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES   = 1024,
    parameter int unsigned GLITCH_CYCLES = 8,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                gbt_rxready_raw_i,
    input  logic                gbt_rxvalid_raw_i,
    input  logic                gbt_txready_raw_i,
    input  logic                cnt_reset_i,
    output logic                gbt_rxready_o,
    output logic                gbt_rxvalid_o,
    output logic                gbt_txready_o,
    output logic                link_ok_o,
    output logic                link_lost_o,
    output logic [CNT_BITS-1:0] glitch_cnt_o,
    output logic [CNT_BITS-1:0] unlock_cnt_o,
    output logic [1:0]          state_o
);

    localparam int unsigned CntMax = (LOCK_CYCLES > GLITCH_CYCLES) ? LOCK_CYCLES : GLITCH_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_CYCLES - 1);
    localparam logic [CntW-1:0] GlitchLast = CntW'(GLITCH_CYCLES - 1);

    logic rxready_s;
    logic rxvalid_s;
    logic txready_s;
    logic all_ok;

`ifdef GBT_LINK_MON_SYNC_EN
    bit_sync_2ff u_sync_rxready (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (gbt_rxready_raw_i),
        .q_o     (rxready_s)
    );

    bit_sync_2ff u_sync_rxvalid (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (gbt_rxvalid_raw_i),
        .q_o     (rxvalid_s)
    );

    bit_sync_2ff u_sync_txready (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (gbt_txready_raw_i),
        .q_o     (txready_s)
    );
`else
    assign rxready_s = gbt_rxready_raw_i;
    assign rxvalid_s = gbt_rxvalid_raw_i;
    assign txready_s = gbt_txready_raw_i;
`endif

    assign all_ok = rxready_s & rxvalid_s & txready_s;

    gbt_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                link_ok_q, link_ok_d;
    logic                link_lost_q, link_lost_d;
    logic [CNT_BITS-1:0] glitch_cnt_q, glitch_cnt_d;
    logic [CNT_BITS-1:0] unlock_cnt_q, unlock_cnt_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_DOWN;
            cnt_q        <= '0;
            link_ok_q    <= 1'b0;
            link_lost_q  <= 1'b0;
            glitch_cnt_q <= '0;
            unlock_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            link_ok_q    <= link_ok_d;
            link_lost_q  <= link_lost_d;
            glitch_cnt_q <= glitch_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_DOWN: begin
                if (all_ok) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_QUALIFY: begin
                if (!all_ok) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = ST_UP;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            ST_UP: begin
                if (!all_ok) begin
                    state_d = ST_DROP;
                    cnt_d   = CntW'(1);
                end
            end
            ST_DROP: begin
                if (all_ok) begin
                    state_d = ST_UP;
                end else if (cnt_q == GlitchLast) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ST_DOWN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they land on the transition edge.
    always_comb begin
        link_ok_d   = (state_d == ST_UP) || (state_d == ST_DROP);
        link_lost_d = (state_q == ST_DROP) && (state_d == ST_DOWN);
    end

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        if ((state_q == ST_DROP) && (state_d == ST_UP)) begin
            glitch_cnt_d = CNT_BITS'(sat_inc(32'(glitch_cnt_q), CNT_BITS));
        end
        if ((state_q == ST_DROP) && (state_d == ST_DOWN)) begin
            unlock_cnt_d = CNT_BITS'(sat_inc(32'(unlock_cnt_q), CNT_BITS));
        end
        // A clear coinciding with an increment must leave zero.
        if (cnt_reset_i) begin
            glitch_cnt_d = '0;
            unlock_cnt_d = '0;
        end
    end

    assign link_ok_o     = link_ok_q;
    assign gbt_rxready_o = link_ok_q;
    assign gbt_rxvalid_o = link_ok_q;
    assign gbt_txready_o = link_ok_q;
    assign link_lost_o   = link_lost_q;
    assign glitch_cnt_o  = glitch_cnt_q;
    assign unlock_cnt_o  = unlock_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_gbt_link_monitor.sv
// Self-checking bench for gbt_link_monitor: directed scenarios plus randomized bursts
// checked against a run-length reference model.
module tb_gbt_link_monitor;

    localparam int unsigned Lock    = 16;
    localparam int unsigned Glitch  = 4;
    localparam int unsigned CntBits = 4;
    localparam int unsigned CntSat  = (1 << CntBits) - 1;
`ifdef GBT_LINK_MON_SYNC_EN
    localparam int unsigned LatAdd = 2;
`else
    localparam int unsigned LatAdd = 0;
`endif

    logic               clock_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               rxready_raw = 1'b0;
    logic               rxvalid_raw = 1'b0;
    logic               txready_raw = 1'b0;
    logic               cnt_reset = 1'b0;
    logic               rxready_q;
    logic               rxvalid_q;
    logic               txready_q;
    logic               link_ok;
    logic               link_lost;
    logic [CntBits-1:0] glitch_cnt;
    logic [CntBits-1:0] unlock_cnt;
    logic [1:0]         state;

    gbt_link_monitor #(
        .LOCK_CYCLES   (Lock),
        .GLITCH_CYCLES (Glitch),
        .CNT_BITS      (CntBits)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .gbt_rxready_raw_i (rxready_raw),
        .gbt_rxvalid_raw_i (rxvalid_raw),
        .gbt_txready_raw_i (txready_raw),
        .cnt_reset_i       (cnt_reset),
        .gbt_rxready_o     (rxready_q),
        .gbt_rxvalid_o     (rxvalid_q),
        .gbt_txready_o     (txready_q),
        .link_ok_o         (link_ok),
        .link_lost_o       (link_lost),
        .glitch_cnt_o      (glitch_cnt),
        .unlock_cnt_o      (unlock_cnt),
        .state_o           (state)
    );

    always #5 clock_i = ~clock_i;

    int tests_run    = 0;
    int tests_failed = 0;
    int lost_seen    = 0;

    // Reference model: link is up/down; track consecutive good run while down,
    // consecutive bad run while up.
    bit       m_up;
    int       m_good;
    int       m_bad;
    int       m_glitch;
    int       m_unlock;
    bit       m_lost;
    bit [1:0] m_pipe;

    task automatic model_reset();
        m_up = 0; m_good = 0; m_bad = 0;
        m_glitch = 0; m_unlock = 0; m_lost = 0; m_pipe = 2'b00;
    endtask

    task automatic model_edge(input bit ok, input bit crst);
        bit s;
`ifdef GBT_LINK_MON_SYNC_EN
        s = m_pipe[1];
        m_pipe = {m_pipe[0], ok};
`else
        s = ok;
`endif
        m_lost = 0;
        if (!m_up) begin
            m_good = s ? m_good + 1 : 0;
            if (m_good == Lock) begin
                m_up  = 1;
                m_bad = 0;
            end
        end else if (!s) begin
            m_bad++;
            if (m_bad == Glitch) begin
                m_up   = 0;
                m_lost = 1;
                m_good = 0;
                m_bad  = 0;
                if (m_unlock < CntSat) m_unlock++;
            end
        end else if (m_bad > 0) begin
            m_bad = 0;
            if (m_glitch < CntSat) m_glitch++;
        end
        if (crst) begin
            m_glitch = 0;
            m_unlock = 0;
        end
    endtask

    function automatic int m_state();
        if (!m_up) return (m_good == 0) ? 0 : 1;
        return (m_bad == 0) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " link_ok"}, 32'(link_ok), 32'(m_up));
        check({tag, " rxready"}, 32'(rxready_q), 32'(m_up));
        check({tag, " rxvalid"}, 32'(rxvalid_q), 32'(m_up));
        check({tag, " txready"}, 32'(txready_q), 32'(m_up));
        check({tag, " link_lost"}, 32'(link_lost), 32'(m_lost));
        check({tag, " glitch_cnt"}, 32'(glitch_cnt), 32'(m_glitch));
        check({tag, " unlock_cnt"}, 32'(unlock_cnt), 32'(m_unlock));
        check({tag, " state"}, 32'(state), 32'(m_state()));
    endtask

    // Drive at the falling edge, clock once, compare at the next falling edge.
    task automatic step(input logic rx, input logic rv, input logic tx, input logic crst,
                        input string tag);
        rxready_raw = rx;
        rxvalid_raw = rv;
        txready_raw = tx;
        cnt_reset   = crst;
        @(posedge clock_i);
        model_edge(rx & rv & tx, crst);
        @(negedge clock_i);
        cnt_reset = 1'b0;
        if (link_lost === 1'b1) lost_seen++;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_i = 1'b1;
        #1;
        check({tag, " async link_ok"}, 32'(link_ok), 32'd0);
        check({tag, " async link_lost"}, 32'(link_lost), 32'd0);
        check({tag, " async glitch"}, 32'(glitch_cnt), 32'd0);
        check({tag, " async unlock"}, 32'(unlock_cnt), 32'd0);
        check({tag, " async state"}, 32'(state), 32'd0);
        model_reset();
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    initial begin
        int glen;
        int blen;
        logic [2:0] pat;
        model_reset();
        repeat (2) @(negedge clock_i);
        check_all("reset");
        reset_i = 1'b0;

        // 1: sustained good link comes up on the Lock-th edge
        for (int i = 1; i <= int'(Lock + LatAdd); i++) begin
            step(1, 1, 1, 0, "t1");
            check("t1 rise edge", 32'(link_ok), 32'(i >= int'(Lock + LatAdd)));
        end

        // 2: single dip mid-qualification restarts from zero
        do_reset("t2");
        repeat (10) step(1, 1, 1, 0, "t2 pre");
        step(1, 0, 1, 0, "t2 dip");
        repeat (LatAdd) step(1, 1, 1, 0, "t2 lat");
        check("t2 state after dip", 32'(state), 32'd0);
        for (int i = 1; i <= int'(Lock); i++) begin
            step(1, 1, 1, 0, "t2 requal");
            check("t2 requal link_ok", 32'(link_ok), 32'(i == int'(Lock)));
        end
        check("t2 glitch", 32'(glitch_cnt), 32'd0);

        // 3: short drop is a glitch, not an unlock
        lost_seen = 0;
        repeat (3) step(0, 1, 1, 0, "t3 low");
        repeat (LatAdd + 1) step(1, 1, 1, 0, "t3 rec");
        check("t3 link_ok", 32'(link_ok), 32'd1);
        check("t3 glitch", 32'(glitch_cnt), 32'd1);
        check("t3 unlock", 32'(unlock_cnt), 32'd0);
        check("t3 lost pulses", 32'(lost_seen), 32'd0);

        // 4: sustained drop takes the link down
        repeat (Glitch + LatAdd) step(1, 1, 0, 0, "t4 low");
        check("t4 link_ok", 32'(link_ok), 32'd0);
        check("t4 unlock", 32'(unlock_cnt), 32'd1);
        check("t4 state", 32'(state), 32'd0);
        check("t4 lost pulses", 32'(lost_seen), 32'd1);

        // 5: glitch counter saturates; clear wins over a coincident increment
        repeat (Lock + LatAdd) step(1, 1, 1, 0, "t5 up");
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 1, 0, "t5 glitch");
            step(1, 1, 1, 0, "t5 rec");
        end
        repeat (LatAdd) step(1, 1, 1, 0, "t5 lat");
        check("t5 glitch sat", 32'(glitch_cnt), 32'(CntSat));
        step(1, 0, 1, 0, "t5 glitch18");
        repeat (LatAdd) step(1, 1, 1, 0, "t5 lat2");
        step(1, 1, 1, 1, "t5 clr");
        check("t5 glitch cleared", 32'(glitch_cnt), 32'd0);
        check("t5 link_ok", 32'(link_ok), 32'd1);

        // 6: asynchronous reset while up
        do_reset("t6");
        check_all("t6 post");

        // Randomized bursts of good and bad samples
        for (int b = 0; b < 60; b++) begin
            glen = $urandom_range(1, 24);
            for (int i = 0; i < glen; i++) step(1, 1, 1, ($urandom_range(0, 31) == 0), "rnd good");
            blen = $urandom_range(1, 6);
            for (int i = 0; i < blen; i++) begin
                pat = 3'($urandom_range(0, 6));
                step(pat[0], pat[1], pat[2], ($urandom_range(0, 31) == 0), "rnd bad");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gbt_link_monitor.md
Name: gbt_link_monitor

Overview:
- Qualifies and debounces raw GBT link status (rxready, rxvalid, txready) before it reaches the startup/hold reset generator.
- Filters short dropouts and requires a sustained good link before reporting it up.
- Counts glitches and full unlocks for slow-control monitoring.
- Emits a one-cycle link-lost strobe usable as a soft-reset request.

Parameters:
- LOCK_CYCLES, 1024: consecutive all-good samples required to declare the link up; legal range ≥2.
- GLITCH_CYCLES, 8: consecutive bad samples that declare the link down; shorter drops count as glitches; legal range ≥2.
- CNT_BITS, 16: width of each saturating event counter.

Ports:
- clock_i  in  1  system clock (40 MHz bx clock).
- reset_i  in  1  asynchronous, active-high reset.
- gbt_rxready_raw_i  in  1  raw GBT rx ready.
- gbt_rxvalid_raw_i  in  1  raw GBT rx header valid.
- gbt_txready_raw_i  in  1  raw GBT tx ready.
- cnt_reset_i  in  1  synchronous clear of both counters; single-cycle pulse.
- gbt_rxready_o  out  1  qualified rx ready; equals link_ok_o.
- gbt_rxvalid_o  out  1  qualified rx valid; equals link_ok_o.
- gbt_txready_o  out  1  qualified tx ready; equals link_ok_o.
- link_ok_o  out  1  filtered link-good flag.
- link_lost_o  out  1  one-cycle strobe on link declared down.
- glitch_cnt_o  out  CNT_BITS  filtered-dropout count, saturating.
- unlock_cnt_o  out  CNT_BITS  link-down event count, saturating.
- state_o  out  2  current FSM state, for monitoring.

Behaviour:
- All outputs are registered.
- Async reset: state DOWN, internal cnt 0, all outputs 0 immediately, with no clock edge needed.
- all_ok = rxready & rxvalid & txready, using sampled (or synchronized) inputs.
- FSM (encoding DOWN=0, QUALIFY=1, UP=2, DROP=3):
  - DOWN: all_ok → QUALIFY, cnt<=1. Otherwise stay, cnt<=0.
  - QUALIFY: !all_ok → DOWN, cnt<=0. Else if cnt==LOCK_CYCLES-1 → UP. Else cnt++.
  - UP: !all_ok → DROP, cnt<=1. Else stay.
  - DROP: all_ok → UP, glitch_cnt++. Else if cnt==GLITCH_CYCLES-1 → DOWN, unlock_cnt++, link_lost_o<=1 for one cycle. Else cnt++.
- link_ok_o rises on the same edge that enters UP, i.e. the LOCK_CYCLES-th consecutive all-good sampling edge.
- link_ok_o is 1 in UP and DROP, and falls on the GLITCH_CYCLES-th consecutive bad sampling edge. link_lost_o asserts on that same edge.
- Drops of 1..GLITCH_CYCLES-1 cycles never deassert link_ok_o.
- Any single bad sample in QUALIFY restarts qualification from zero.
- Counters saturate at 2^CNT_BITS-1 and never wrap.
- cnt_reset_i clears both counters to 0. If a clear coincides with an increment, the clear wins and the result is 0.
- cnt_reset_i has no effect on the FSM.
- cnt width = clog2(max(LOCK_CYCLES, GLITCH_CYCLES)) bits.

Optional Feature:
- Macro GBT_LINK_MON_SYNC_EN.
- Defined: each raw input passes through a 2-flop synchronizer into clock_i (flops reset to 0 by reset_i). All latencies above grow by exactly 2 cycles.
- Undefined: raw inputs are used directly and assumed already in the clock_i domain; latencies are exactly as stated.

Decomposition:
- Package gbt_link_mon_pkg holds:
  - the 2-bit state type with the constants ST_DOWN, ST_QUALIFY, ST_UP, ST_DROP;
  - a saturating-increment function parameterized by width.
- One sub-module, bit_sync_2ff (1-bit, async-reset, 2-flop synchronizer), instantiated three times only under GBT_LINK_MON_SYNC_EN.

Test Plan (bench params LOCK_CYCLES=16, GLITCH_CYCLES=4, CNT_BITS=4, macro undefined unless stated):
1. Release reset, hold all raw inputs high → link_ok_o and the three qualified outputs are 0 for 15 edges and rise on the 16th. state_o goes 0→1→2.
2. In QUALIFY at cnt=10, drop rxvalid for 1 cycle then restore → state_o returns to 0. link_ok_o rises 16 edges after restore. No counter changes.
3. In UP, rxready low 3 cycles → link_ok_o stays 1, glitch_cnt_o 0→1, unlock_cnt_o stays 0, link_lost_o never asserts.
4. In UP, txready low 4 cycles → link_ok_o falls on the 4th low edge, link_lost_o high exactly 1 cycle, unlock_cnt_o=1, state_o=0.
5. Generate 17 one-cycle glitches → glitch_cnt_o saturates at 15. Then pulse cnt_reset_i on the same edge as an 18th glitch recovery → glitch_cnt_o=0.
6. Assert reset_i asynchronously mid-UP → all outputs 0 before the next clock edge. With GBT_LINK_MON_SYNC_EN, repeat scenario 1 → link_ok_o rises on the 18th edge.
